stream_fifo: RTL
================

Name: stream_fifo

Overview:
Next-generation synchronous buffer for the core datapath. It replaces raw enable/flag FIFOs with valid/ready streaming on both sides and supports any depth (not only powers of two). It also adds occupancy reporting, programmable almost-full/almost-empty flags, synchronous flush and a peak-occupancy monitor. It sits between producers and consumers such as weight/activation loaders and the systolic array feeders.

Parameters:
DEPTH, 16, number of entries; any integer >= 2.
WIDTH, 8, data word width in bits.
AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL; legal range 0..DEPTH-1.
CW (localparam), $clog2(DEPTH+1), width of the level and peak outputs.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of contents and peak monitor.
in_valid  in  1  producer offers in_data.
in_data  in  WIDTH  write word.
in_ready  out  1  FIFO can accept a word this cycle.
out_valid  out  1  out_data holds the head entry.
out_data  out  WIDTH  head entry, first-word-fall-through.
out_ready  in  1  consumer takes the head this cycle.
level  out  CW  current number of stored entries, 0..DEPTH.
almost_full  out  1  level >= AF_LEVEL.
almost_empty  out  1  level <= AE_LEVEL.
peak_level  out  CW  maximum level reached since reset/flush.

Behaviour:
- Storage: DEPTH x WIDTH array. Read/write pointers are 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking). A registered count holds the level.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (level != DEPTH). A push is never accepted when full, even with a same-cycle pop.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational from registered state.
- out_data is don't-care when out_valid=0. The bench must not check it then.
- Push: mem[wr_ptr] <= in_data, wr_ptr advances. Memory is written only on push; no write when in_valid=0 or when full.
- Pop: rd_ptr advances.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed into an empty FIFO has out_valid=1 with that word on the next cycle. There is no same-cycle bypass.
- Push and pop together at 0 < level < DEPTH: level holds, both pointers advance.
- almost_full / almost_empty are combinational from the registered level. No extra latency.
- peak_level <= max(peak_level, next level) each cycle, so it tracks the post-update level. It saturates at DEPTH.
- flush (highest priority): next cycle pointers=0, level=0, peak_level=0. A same-cycle push and pop are discarded, with no memory write required. in_ready and out_valid are not gated by flush in the flush cycle.
- Reset values: level=0, peak_level=0, out_valid=0, in_ready=1, almost_full=(AF_LEVEL==0 ? 1 : 0), almost_empty=1. Pointers are 0. Memory contents are not reset.
- Reset asserted mid-transfer clears all state asynchronously; in-flight data is lost.
- The full condition requires no extra pointer bit; the count disambiguates full from empty.
- Assertions in simulation: AF_LEVEL and AE_LEVEL within legal range; level never exceeds DEPTH.

Test Plan:
1. DEPTH=5 (non-power-of-two), push 0x01..0x05 with out_ready=0 -> in_ready=0 after 5th push, level=5, almost_full=1. Then drain -> 0x01..0x05 in order, level returns to 0, almost_empty=1, peak_level=5.
2. Empty FIFO, in_valid=1 data 0xA5, out_ready=1 -> out_valid=0 that cycle; next cycle out_valid=1, out_data=0xA5, popped, level=0.
3. Level=3, in_valid=1 and out_ready=1 held for 20 cycles with incrementing data -> level stays 3, order preserved, pointers wrap past DEPTH-1 without loss.
4. Full FIFO with in_valid=1 and out_ready=1 -> pop occurs, push rejected (in_ready=0), level=DEPTH-1. Next cycle the push is accepted and level=DEPTH.
5. Level=4, peak=6, assert flush with in_valid=1 -> next cycle level=0, peak_level=0, out_valid=0. The flushed-cycle word never appears at the output.
6. Random valid/ready traffic (10k cycles) against a queue model; assert rst_n low at a random mid-burst cycle -> outputs immediately at reset values; scoreboard resets and order matches afterwards.

Source files
------------

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO, any DEPTH >= 2; a push into an empty FIFO is visible one cycle later.
// in_ready drops only when full (a same-cycle pop does not free a slot); out_valid follows level != 0.
module stream_fifo #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    peak_level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    level_q, level_d;
    logic [CW-1:0]    peak_q, peak_d;
    logic             push, pop;

    assign in_ready     = (level_q != FULL_LVL);
    assign out_valid    = (level_q != '0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign out_data     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign peak_level   = peak_q;
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        peak_d   = peak_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            peak_d   = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths never index past DEPTH-1
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
            peak_d = (level_d > peak_q) ? level_d : peak_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            peak_q   <= peak_d;
        end
    end

    // Storage is not reset; a flushed-cycle push is simply dropped
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (AF_LEVEL >= 1 && AF_LEVEL <= DEPTH)
                else $error("stream_fifo: AF_LEVEL out of range");
            assert (AE_LEVEL >= 0 && AE_LEVEL <= DEPTH - 1)
                else $error("stream_fifo: AE_LEVEL out of range");
            assert (level_q <= FULL_LVL)
                else $error("stream_fifo: level exceeds DEPTH");
        end
    end

endmodule
